// File: rtl/riscv_keypad_scanner_pkg.sv
// Shared definitions for the 4x4 matrix keypad scanner.
//   - kp_state_t : scanner FSM state encoding (2 bits)
//   - KB_WIDTH   : width of the keyboard register. The IO bridge returns this
//                  register at address 0xfffffc08 and uses the same width for
//                  its keyboard input.
//   - kp_hex_code: maps a (row, column) position to the printed keypad legend.
package riscv_keypad_scanner_pkg;

    localparam int KB_WIDTH = 5;

    typedef enum logic [1:0] {
        KP_SCAN     = 2'd0,
        KP_DEBOUNCE = 2'd1,
        KP_HOLD     = 2'd2,
        KP_RELEASE  = 2'd3
    } kp_state_t;

    // Legend: row0 1 2 3 A / row1 4 5 6 B / row2 7 8 9 C / row3 * 0 # D.
    // '*' is reported as E and '#' as F.
    function automatic logic [3:0] kp_hex_code(input logic [1:0] row, input logic [1:0] col);
        logic [3:0] code;
        case ({row, col})
            4'h0: code = 4'h1;
            4'h1: code = 4'h2;
            4'h2: code = 4'h3;
            4'h3: code = 4'hA;
            4'h4: code = 4'h4;
            4'h5: code = 4'h5;
            4'h6: code = 4'h6;
            4'h7: code = 4'hB;
            4'h8: code = 4'h7;
            4'h9: code = 4'h8;
            4'hA: code = 4'h9;
            4'hB: code = 4'hC;
            4'hC: code = 4'hE;
            4'hD: code = 4'h0;
            4'hE: code = 4'hF;
            default: code = 4'hD;
        endcase
        return code;
    endfunction

endpackage

// File: rtl/riscv_keypad_scanner_if.sv
// Keypad-side bundle of the scanner.
//   row_in    : keypad rows, active-low, asynchronous to clk
//   col_out   : column strobes, active-low, one-cold
//   keyboard  : {held, code} register read by the IO bridge
//   key_event : one-cycle pulse per accepted press
// The master modport is the scanner; the slave modport is the keypad/consumer side.
interface riscv_keypad_scanner_if;
    import riscv_keypad_scanner_pkg::*;

    logic [3:0]          row_in;
    logic [3:0]          col_out;
    logic [KB_WIDTH-1:0] keyboard;
    logic                key_event;

    modport master (input row_in, output col_out, output keyboard, output key_event);
    modport slave  (output row_in, input col_out, input keyboard, input key_event);
endinterface

// File: rtl/riscv_keypad_scanner_sync2.sv
// Generic two-flop synchronizer with a per-bit reset value.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   rst_val    : value loaded into both stages while in reset
//   d          : asynchronous input
//   q          : synchronized output (two clk cycles of latency)
module riscv_keypad_scanner_sync2 #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] rst_val,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta;
    logic [WIDTH-1:0] sync;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= rst_val;
            sync <= rst_val;
        end else begin
            meta <= d;
            sync <= meta;
        end
    end

    assign q = sync;

endmodule

// File: rtl/riscv_keypad_scanner.sv
// 4x4 matrix keypad scanner producing the 5-bit keyboard register.
// Rotates an active-low column strobe, samples the synchronized rows at the
// end of each column window, debounces press and release, and reports
// {held, code} plus a single-cycle key_event per accepted press.
// Ports:
//   clk   : system clock
//   rst_n : asynchronous active-low reset
//   kp    : riscv_keypad_scanner_if.master (row_in, col_out, keyboard, key_event)
// Parameters:
//   SCAN_DIV     : cycles each column is driven before rows are sampled (>= 4)
//   DEBOUNCE_CYC : consecutive stable cycles to accept a press or release (>= 2)
// Build option:
//   KEYPAD_HEX_MAP_EN : when defined, code follows the keypad legend;
//                       otherwise code = {row_idx, col_idx}.
module riscv_keypad_scanner
    import riscv_keypad_scanner_pkg::*;
#(
    parameter int SCAN_DIV     = 1000,
    parameter int DEBOUNCE_CYC = 100000
) (
    input  logic                   clk,
    input  logic                   rst_n,
    riscv_keypad_scanner_if.master kp
);

    localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int CNT_W = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYC - 1);

    logic [3:0]          rs;
    kp_state_t           state;
    logic [DIV_W-1:0]    div;
    logic [CNT_W-1:0]    cnt;
    logic [1:0]          col_idx;
    logic [1:0]          row_idx;
    logic [3:0]          col_q;
    logic [KB_WIDTH-1:0] kb_q;
    logic                evt_q;
    logic [1:0]          low_row;
    logic                row_low;
    logic [3:0]          new_code;

    riscv_keypad_scanner_sync2 #(.WIDTH(4)) u_row_sync (
        .clk     (clk),
        .rst_n   (rst_n),
        .rst_val (4'hF),
        .d       (kp.row_in),
        .q       (rs)
    );

    // Lowest-index low row wins when several rows are pulled down.
    always_comb begin
        low_row = 2'd3;
        if (!rs[0])      low_row = 2'd0;
        else if (!rs[1]) low_row = 2'd1;
        else if (!rs[2]) low_row = 2'd2;
    end

    assign row_low = ~rs[row_idx];

`ifdef KEYPAD_HEX_MAP_EN
    assign new_code = kp_hex_code(row_idx, col_idx);
`else
    assign new_code = {row_idx, col_idx};
`endif

    // Counters only increment below their terminal value, so they saturate
    // rather than wrap. col_q is kept as its own register so the strobes come
    // straight from flops and never glitch.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= KP_SCAN;
            div     <= '0;
            cnt     <= '0;
            col_idx <= 2'd0;
            row_idx <= 2'd0;
            col_q   <= 4'b1110;
            kb_q    <= '0;
            evt_q   <= 1'b0;
        end else begin
            evt_q <= 1'b0;
            case (state)
                KP_SCAN: begin
                    if (div != DIV_LAST) begin
                        div <= div + 1'b1;
                    end else begin
                        div <= '0;
                        if (rs == 4'hF) begin
                            col_q   <= {col_q[2:0], col_q[3]};
                            col_idx <= col_idx + 2'd1;
                        end else begin
                            row_idx <= low_row;
                            cnt     <= '0;
                            state   <= KP_DEBOUNCE;
                        end
                    end
                end
                KP_DEBOUNCE: begin
                    if (!row_low) begin
                        state   <= KP_SCAN;
                        div     <= '0;
                        col_q   <= {col_q[2:0], col_q[3]};
                        col_idx <= col_idx + 2'd1;
                    end else if (cnt == CNT_LAST) begin
                        state <= KP_HOLD;
                        kb_q  <= {1'b1, new_code};
                        evt_q <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                KP_HOLD: begin
                    if (!row_low) begin
                        state <= KP_RELEASE;
                        cnt   <= '0;
                    end
                end
                KP_RELEASE: begin
                    // A row dropping again is treated as bounce on release:
                    // the key stays held and no new event is raised.
                    if (row_low) begin
                        state <= KP_HOLD;
                    end else if (cnt == CNT_LAST) begin
                        state              <= KP_SCAN;
                        div                <= '0;
                        kb_q[KB_WIDTH-1]   <= 1'b0;
                        col_q              <= {col_q[2:0], col_q[3]};
                        col_idx            <= col_idx + 2'd1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= KP_SCAN;
            endcase
        end
    end

    assign kp.col_out   = col_q;
    assign kp.keyboard  = kb_q;
    assign kp.key_event = evt_q;

endmodule

// File: doc/riscv_keypad_scanner.md
Name: riscv_keypad_scanner

Overview:
Device-side producer of the 5-bit keyboard value that the IO bridge returns at 0xfffffc08. Drives a 4x4 matrix keypad by rotating an active-low column strobe and synchronizing the row inputs. It debounces press and release, then presents {held, code} as a register. It also emits a one-cycle pulse for each new debounced press.

Parameters:
SCAN_DIV, 1000, clock cycles each column is driven before the rows are sampled; minimum 4 (2-flop sync plus settling).
DEBOUNCE_CYC, 100000, consecutive stable cycles required to accept a press or a release; minimum 2.

Ports:
clk  input  1  system clock
rst_n  input  1  reset, asynchronous, active-low
row_in  input  4  keypad rows, active-low, externally pulled up, asynchronous to clk
col_out  output  4  column strobes, active-low, exactly one bit low at all times
keyboard  output  5  [4]=key currently held (debounced), [3:0]=code of last accepted key
key_event  output  1  single-cycle pulse on each accepted press

Behaviour:
- Reset (rst_n low, asynchronous): col_out=4'b1110 (column 0), keyboard=5'h00, key_event=0, state SCAN, all counters 0, synchronizer flops=4'hF.
- row_in passes through a 2-flop synchronizer; the logic below uses only the synchronized value rs.
- States: SCAN, DEBOUNCE, HOLD, RELEASE.
- SCAN:
  - div counts 0..SCAN_DIV-1 while the current column is driven.
  - At div==SCAN_DIV-1: if rs==4'hF, advance to the next column (3 wraps to 0) and clear div.
  - Otherwise latch col_idx and row_idx. row_idx is the lowest-index low row; lower row wins on multiple presses. Go to DEBOUNCE with cnt=0 and the column frozen.
- DEBOUNCE:
  - Each cycle with rs[row_idx]==0: cnt++.
  - When cnt==DEBOUNCE_CYC-1 and still low, on the next edge: go to HOLD, set keyboard={1,code}, key_event=1 for exactly that cycle.
  - Any cycle with rs[row_idx]==1: return to SCAN, advance the column, clear div; no output change.
- HOLD: column stays frozen; other keys are ignored. When rs[row_idx]==1, go to RELEASE with cnt=0.
- RELEASE:
  - Needs DEBOUNCE_CYC consecutive cycles of rs[row_idx]==1. Then go to SCAN, set keyboard[4]=0, keep keyboard[3:0], advance the column.
  - rs[row_idx]==0 during RELEASE returns to HOLD with no new key_event.
- key_event is never high for two consecutive cycles. keyboard[3:0] changes only on an accepted press.
- Worst-case press latency from a stable row: up to 4*SCAN_DIV + DEBOUNCE_CYC + 2 cycles.
- Counter widths are $clog2 of the respective parameter. Counters saturate and never wrap inside a state.
- rst_n asserted mid-DEBOUNCE/HOLD/RELEASE: immediate return to reset values; no key_event.

Optional Feature:
KEYPAD_HEX_MAP_EN
- Defined: code follows the keypad legend.
  - row0: 1,2,3,A
  - row1: 4,5,6,B
  - row2: 7,8,9,C
  - row3: '*'=E, 0, '#'=F, D
- Undefined: raw code = {row_idx[1:0], col_idx[1:0]}.
- Mapping is combinational at the latch point; latency is identical in both builds.

Decomposition:
- riscv_defs.v holds:
  - state encodings: `KP_SCAN, `KP_DEBOUNCE, `KP_HOLD, `KP_RELEASE (2 bits)
  - `KB_WIDTH 5 (shared with riscv_io_bridge keyboard input)
  - IO address constant 0xfffffc08 for documentation consistency
- One natural sub-module: riscv_sync2, a parameterized-width 2-flop synchronizer with reset value input, reused for sw inputs later.

Test Plan:
All cases use SCAN_DIV=4, DEBOUNCE_CYC=8.
- Reset: rst_n=0 with arbitrary row_in -> col_out=4'b1110, keyboard=5'h00, key_event=0. Release rst_n with rows idle -> col_out rotates 1110→1101→1011→0111→1110, 4 cycles each.
- Clean press, row3 low whenever col0 is driven, held for 40 cycles -> one key_event pulse; keyboard=5'h1C raw, or 5'h1E with KEYPAD_HEX_MAP_EN; col_out frozen at 4'b1110 while held.
- Bounce: row1 low for 5 cycles at col2 -> no key_event, keyboard unchanged, scan resumes at col3.
- Release: after the press above, rows go 4'hF -> keyboard=5'h0C (raw) 8 cycles after the synchronized release; scan resumes at col1. Release glitch: re-press within 3 cycles of release -> stays held, keyboard[4]=1, no second key_event.
- Multi-key: row0 and row2 low at col1 -> keyboard=5'h11 raw (5'h12 hex). A later row2 press at col3 while row0 is held is ignored.
- Reset mid-DEBOUNCE (cnt=5) -> outputs return to reset values immediately; no key_event afterwards until a new full debounce.
